// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen -- parametrised program-counter generator
//
// Purpose:
//   Produces the fetch address for the core. Each cycle it picks the next PC
//   from one of four sources: sequential, conditional branch, JAL or JALR.
//   The PC can be held with a stall, loaded with a reset vector, and
//   redirected to a trap vector when the selected target is not word aligned.
//   On a trap the faulting PC is saved in epc. A later trap_ret jumps back to
//   that PC; the block does not add 4 to it.
//
// Ports:
//   clk           in   1      clock, every state update on the rising edge
//   rst           in   1      synchronous active-low reset
//   stall         in   1      hold the PC, the next-PC selection is ignored
//   pc_src        in   2      00 seq, 01 cond branch, 10 JAL, 11 JALR
//   branch_taken  in   1      branch condition, only used when pc_src == 01
//   imm_ext       in   WIDTH  sign-extended immediate
//   rs1           in   WIDTH  JALR base register value
//   trap_ret      in   1      return from trap, PC <= epc
//   pc            out  WIDTH  current PC (registered)
//   pc_plus4      out  WIDTH  pc + 4 modulo 2^WIDTH, combinational from pc
//   trap          out  1      high for the single cycle spent in TRAP
//   epc           out  WIDTH  PC of the instruction whose target faulted
//   trap_cnt      out  CNT_W  number of traps taken, saturating
// ============================================================================
module pc_gen #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] rs1,
    input  logic             trap_ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             trap,
    output logic [WIDTH-1:0] epc,
    output logic [CNT_W-1:0] trap_cnt
);

    // The vectors are 32-bit parameters. Narrow configurations keep only
    // the low WIDTH bits.
    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] TRAP_PC  = WIDTH'(TRAP_VEC);

    // Next-PC source encodings
    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JAL  = 2'b10;
    localparam logic [1:0] SRC_JALR = 2'b11;

    // Mask that clears bit 0 of a JALR sum
    localparam logic [WIDTH-1:0] JALR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    // Architectural state
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] epc_q,      epc_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    state_t           state_q,    state_d;
    logic             trap_q,     trap_d;

    // Candidate targets. Every adder is exactly WIDTH bits wide, so the
    // carry out is dropped and the PC wraps modulo 2^WIDTH.
    logic [WIDTH-1:0] seq_target;
    logic [WIDTH-1:0] rel_target;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] jalr_target;
    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             cnt_full;

    assign seq_target  = pc_q + WIDTH'(4);
    assign rel_target  = pc_q + imm_ext;
    assign jalr_sum    = rs1 + imm_ext;
    assign jalr_target = jalr_sum & JALR_MASK;

    // Select the next-PC target. A not-taken branch falls through to the
    // sequential address. Only the selected target is checked for
    // alignment, so an unused adder holding an odd value never traps.
    always_comb begin
        target = seq_target;
        case (pc_src)
            SRC_SEQ:  target = seq_target;
            SRC_BR:   target = branch_taken ? rel_target : seq_target;
            SRC_JAL:  target = rel_target;
            SRC_JALR: target = jalr_target;
            default:  target = seq_target;
        endcase
    end

    assign misaligned = |target[1:0];
    assign cnt_full   = &trap_cnt_q;

    // Next-state logic for the RUN/TRAP machine and everything it owns.
    // In RUN the priority is: trap_ret, then stall, then a misaligned
    // target, then a normal update. A pending trap_ret overrides stall
    // because the return address in epc does not depend on the stalled
    // instruction. A stalled cycle never traps, because the target it
    // would fault on is not being committed. TRAP lasts exactly one cycle.
    // In that cycle all control inputs are ignored and the PC stays on
    // the trap vector.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        trap_cnt_d = trap_cnt_q;
        state_d    = state_q;

        case (state_q)
            ST_RUN: begin
                if (trap_ret) begin
                    pc_d = epc_q;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (misaligned) begin
                    pc_d    = TRAP_PC;
                    epc_d   = pc_q;
                    state_d = ST_TRAP;
                    if (!cnt_full) begin
                        trap_cnt_d = trap_cnt_q + CNT_W'(1);
                    end
                end else begin
                    pc_d = target;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // trap is registered from the next state, so it is high in exactly
        // the cycle the machine spends in TRAP. No input reaches it
        // combinationally.
        trap_d = (state_d == ST_TRAP);
    end

    // Single state register for the whole block. Reset is synchronous and
    // wins over everything, including a trap that is in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            trap_cnt_q <= '0;
            state_q    <= ST_RUN;
            trap_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            trap_cnt_q <= trap_cnt_d;
            state_q    <= state_d;
            trap_q     <= trap_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = seq_target;
    assign trap     = trap_q;
    assign epc      = epc_q;
    assign trap_cnt = trap_cnt_q;

    // A trap never lasts more than one cycle.
    a_trap_one_cycle : assert property (@(posedge clk) disable iff (!rst)
        trap |=> !trap);

    // The TRAP cycle parks the PC on the trap vector.
    a_trap_pc : assert property (@(posedge clk) disable iff (!rst)
        trap |-> (pc == TRAP_PC));

endmodule

// File: tb/tb_pc_gen.sv
// ============================================================================
// tb_pc_gen -- self-checking bench for pc_gen
//
// Two instances share the clock and control inputs:
//   u_dut_a  default configuration (WIDTH=32, CNT_W=8)
//   u_dut_b  narrow configuration  (WIDTH=8,  CNT_W=2), used for the
//            wrap-around and counter-saturation cases
// A behavioural reference model predicts both instances. For every cycle of
// stimulus it pushes the prediction onto a queue. The entry is popped and
// compared after the clock edge. Directed checks against hand-worked values
// from the test plan are added on top.
// ============================================================================
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic        trap_ret;
    logic [31:0] imm_a, rs1_a;
    logic [7:0]  imm_b, rs1_b;

    logic [31:0] pc_a, pc_plus4_a, epc_a;
    logic [7:0]  trap_cnt_a;
    logic        trap_a;
    logic [7:0]  pc_b, pc_plus4_b, epc_b;
    logic [1:0]  trap_cnt_b;
    logic        trap_b;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic [31:0] pcA;
        logic [31:0] epcA;
        logic [31:0] cntA;
        logic        trapA;
        logic [31:0] pcB;
        logic [31:0] epcB;
        logic [31:0] cntB;
        logic        trapB;
    } expect_t;

    expect_t sbQueue[$];

    // Reference model state: index 0 is instance A, index 1 is instance B.
    logic [31:0] mPc   [2];
    logic [31:0] mEpc  [2];
    int          mCnt  [2];
    logic        mTrap [2];

    pc_gen u_dut_a (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm_ext(imm_a), .rs1(rs1_a),
        .trap_ret(trap_ret), .pc(pc_a), .pc_plus4(pc_plus4_a),
        .trap(trap_a), .epc(epc_a), .trap_cnt(trap_cnt_a)
    );

    pc_gen #(.WIDTH(8), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_taken(branch_taken), .imm_ext(imm_b), .rs1(rs1_b),
        .trap_ret(trap_ret), .pc(pc_b), .pc_plus4(pc_plus4_b),
        .trap(trap_b), .epc(epc_b), .trap_cnt(trap_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stops a hung run and still reports it.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value, count it, and
    // report it if they differ.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one instance of the reference model by one clock edge.
    function automatic void modelStep(input int k, input logic rstN,
                                      input logic stallIn, input logic [1:0] src,
                                      input logic taken, input logic [31:0] imm,
                                      input logic [31:0] rs1v, input logic tret);
        logic [31:0] mask;
        logic [31:0] tgt;
        int          cntMax;
        mask   = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        cntMax = (k == 0) ? 255 : 3;
        tgt    = 32'h0;
        if (!rstN) begin
            mPc[k]   = 32'h0;
            mEpc[k]  = 32'h0;
            mCnt[k]  = 0;
            mTrap[k] = 1'b0;
        end else if (mTrap[k]) begin
            mTrap[k] = 1'b0;
        end else if (tret) begin
            mPc[k] = mEpc[k];
        end else if (!stallIn) begin
            case (src)
                2'd0: tgt = mPc[k] + 32'd4;
                2'd1: tgt = taken ? (mPc[k] + imm) : (mPc[k] + 32'd4);
                2'd2: tgt = mPc[k] + imm;
                default: tgt = (rs1v + imm) & 32'hFFFF_FFFE;
            endcase
            tgt = tgt & mask;
            if (tgt[1:0] != 2'b00) begin
                mEpc[k]  = mPc[k];
                mPc[k]   = 32'h0000_0100 & mask;
                mTrap[k] = 1'b1;
                if (mCnt[k] < cntMax) mCnt[k] = mCnt[k] + 1;
            end else begin
                mPc[k] = tgt;
            end
        end
    endfunction

    // Pop the prediction for this edge and compare every output of both
    // instances against it.
    task automatic checkScoreboard();
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_underflow", 32'(sbQueue.size()), 32'd1);
            return;
        end
        e = sbQueue.pop_front();
        checkOutput("a_pc",       pc_a,              e.pcA);
        checkOutput("a_pc_plus4", pc_plus4_a,        e.pcA + 32'd4);
        checkOutput("a_trap",     {31'h0, trap_a},   {31'h0, e.trapA});
        checkOutput("a_epc",      epc_a,             e.epcA);
        checkOutput("a_trap_cnt", {24'h0, trap_cnt_a}, e.cntA);
        checkOutput("b_pc",       {24'h0, pc_b},     e.pcB);
        checkOutput("b_pc_plus4", {24'h0, pc_plus4_b}, (e.pcB + 32'd4) & 32'hFF);
        checkOutput("b_trap",     {31'h0, trap_b},   {31'h0, e.trapB});
        checkOutput("b_epc",      {24'h0, epc_b},    e.epcB);
        checkOutput("b_trap_cnt", {30'h0, trap_cnt_b}, e.cntB);
    endtask

    // Drive one cycle of stimulus, push the model's prediction, clock once,
    // then check the outputs 1 time unit after the edge.
    task automatic applyStimulus(input logic rstN, input logic stallIn,
                                 input logic [1:0] src, input logic taken,
                                 input logic [31:0] imm, input logic [31:0] rs1v,
                                 input logic tret);
        expect_t e;
        rst          = rstN;
        stall        = stallIn;
        pc_src       = src;
        branch_taken = taken;
        imm_a        = imm;
        rs1_a        = rs1v;
        imm_b        = imm[7:0];
        rs1_b        = rs1v[7:0];
        trap_ret     = tret;
        modelStep(0, rstN, stallIn, src, taken, imm, rs1v, tret);
        modelStep(1, rstN, stallIn, src, taken, imm, rs1v, tret);
        e.pcA   = mPc[0];
        e.epcA  = mEpc[0];
        e.cntA  = 32'(mCnt[0]);
        e.trapA = mTrap[0];
        e.pcB   = mPc[1];
        e.epcB  = mEpc[1];
        e.cntB  = 32'(mCnt[1]);
        e.trapB = mTrap[1];
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        checkScoreboard();
    endtask

    int          expCnt [5] = '{1, 2, 3, 3, 3};
    logic [31:0] immTable [8] = '{32'h0, 32'h4, 32'hFFFF_FFF8, 32'h1,
                                  32'h2, 32'h40, 32'hFFFF_FFFC, 32'h3};

    initial begin
        for (int k = 0; k < 2; k++) begin
            mPc[k] = 32'h0; mEpc[k] = 32'h0; mCnt[k] = 0; mTrap[k] = 1'b0;
        end

        // Reset for two cycles, then run sequentially.
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("rst_pc",       pc_a,               32'h0);
        checkOutput("rst_trap",     {31'h0, trap_a},    32'h0);
        checkOutput("rst_trap_cnt", {24'h0, trap_cnt_a}, 32'h0);
        checkOutput("rst_epc",      epc_a,              32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput("seq_pc", pc_a, 32'(4 * (i + 1)));
        end
        checkOutput("seq_pc_plus4", pc_plus4_a, 32'h14);

        // Taken branch back by 8 from 0x10, then a not-taken branch.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0);
        checkOutput("br_taken_pc", pc_a, 32'h08);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
        checkOutput("br_not_taken_pc", pc_a, 32'h0C);

        // Stall holds the PC, even when the target is misaligned.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput("stall_pc", pc_a, 32'h0C);
        end
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h1, 32'h0, 1'b0);
        checkOutput("stall_mis_pc",   pc_a,            32'h0C);
        checkOutput("stall_mis_trap", {31'h0, trap_a}, 32'h0);

        // A misaligned JALR target traps.
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h1003, 1'b0);
        checkOutput("jalr_trap",     {31'h0, trap_a},    32'h1);
        checkOutput("jalr_trap_pc",  pc_a,               32'h100);
        checkOutput("jalr_epc",      epc_a,              32'h0C);
        checkOutput("jalr_trap_cnt", {24'h0, trap_cnt_a}, 32'h1);

        // trap_ret and stall are ignored during the TRAP cycle.
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("trapcyc_pc",   pc_a,            32'h100);
        checkOutput("trapcyc_trap", {31'h0, trap_a}, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("tret_pc", pc_a, 32'h0C);

        // An aligned JALR target, then trap_ret while stalled.
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h1001, 1'b0);
        checkOutput("jalr_ok_pc",   pc_a,            32'h1000);
        checkOutput("jalr_ok_trap", {31'h0, trap_a}, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("tret_stall_pc", pc_a, 32'h0C);

        // 8-bit wrap-around: 0xFC + 4 -> 0x00 with no trap.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'hF0, 32'h0, 1'b0);
        checkOutput("wrap_pre_pc", {24'h0, pc_b}, 32'hFC);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("wrap_pc",   {24'h0, pc_b},   32'h00);
        checkOutput("wrap_trap", {31'h0, trap_b}, 32'h0);

        // A 2-bit trap counter saturates at 3.
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1, 32'h0, 1'b0);
            checkOutput("sat_trap",     {31'h0, trap_b},     32'h1);
            checkOutput("sat_trap_cnt", {30'h0, trap_cnt_b}, 32'(expCnt[i]));
            applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        end

        // Reset on the TRAP cycle.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1, 32'h0, 1'b0);
        checkOutput("midtrap_pre_trap", {31'h0, trap_a}, 32'h1);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("midtrap_pc",       pc_a,               32'h0);
        checkOutput("midtrap_trap",     {31'h0, trap_a},    32'h0);
        checkOutput("midtrap_trap_cnt", {24'h0, trap_cnt_a}, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("midtrap_run_pc", pc_a, 32'h4);

        // Random mix, checked only by the scoreboard.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 24) != 0),
                          1'($urandom_range(0, 3) == 0),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          immTable[$urandom_range(0, 7)],
                          $urandom(),
                          1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator, the successor to the single-mode PC register.
- Supports sequential, conditional-branch, JAL and JALR next-PC modes, pipeline stall, a reset vector and misaligned-target trapping.
- On a trap it saves the faulting PC and returns to it later.
- Feeds instruction-memory address and PC+4 to fetch/decode. Sits at the front of the core datapath.

Parameters:
- WIDTH, 32, PC / operand width in bits (>= 8).
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH).
- TRAP_VEC, 32'h0000_0100, PC value loaded on a misaligned-target trap (truncated to WIDTH).
- CNT_W, 8, width of the saturating trap counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- stall  in  1  hold PC; next-PC computation ignored.
- pc_src  in  2  00 seq, 01 cond branch, 10 JAL, 11 JALR.
- branch_taken  in  1  condition result, used only when pc_src==01.
- imm_ext  in  WIDTH  sign-extended immediate.
- rs1  in  WIDTH  JALR base register value.
- trap_ret  in  1  return from trap: PC <= epc.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc+4, combinational, modulo 2^WIDTH.
- trap  out  1  high for exactly the one cycle in TRAP state.
- epc  out  WIDTH  PC of the instruction whose target faulted.
- trap_cnt  out  CNT_W  number of traps taken, saturating.

Behaviour:
- Reset (rst==0 at posedge) has priority over every other input and also applies mid-trap:
  - pc=RESET_VEC, epc=0, trap_cnt=0, state=RUN, trap=0.
- Target computation, combinational, all sums modulo 2^WIDTH (carry dropped):
  - 00: pc+4.
  - 01: pc+imm_ext if branch_taken, else pc+4.
  - 10: pc+imm_ext.
  - 11: (rs1+imm_ext) with bit0 forced to 0.
- Misaligned: target[1:0] != 2'b00. Evaluated only for the selected target. pc+4 from an aligned pc never faults.
- FSM states: RUN, TRAP.
- RUN, evaluated at posedge in this priority order:
  - trap_ret=1: pc<=epc; stall is ignored.
  - else stall=1: pc holds. No trap is raised even if the target is misaligned.
  - else target misaligned: pc<=TRAP_VEC, epc<=pc, trap_cnt<=trap_cnt+1 (saturates at 2^CNT_W-1), next state TRAP.
  - else: pc<=target.
- TRAP state:
  - trap=1 for exactly one cycle; pc stays at TRAP_VEC.
  - pc_src, stall, branch_taken and trap_ret are all ignored.
  - Unconditionally returns to RUN next cycle.
- trap is a registered state decode, so it asserts the cycle after the faulting edge. No combinational input-to-trap path.
- trap_ret with epc pointing at a faulting instruction re-executes it. Software/decoder owns skipping it; the block does no automatic +4.
- Latency: next-PC visible on pc one cycle after the qualifying edge.
- pc_plus4 is combinational from the pc register only.

Test Plan:
- Reset/sequential: rst=0 for 2 cycles, then rst=1, pc_src=00 for 4 cycles -> pc=0,0,4,8,12,16. pc_plus4 tracks pc+4; trap=0; trap_cnt=0.
- Branch and stall: pc=0x10, pc_src=01, imm=-8:
  - branch_taken=1 -> pc=0x08.
  - Next cycle taken=0 -> pc=0x0C.
  - stall=1 for 3 cycles -> pc holds 0x0C.
  - Same with stall=1 and a misaligned imm -> no trap.
- JALR alignment: rs1=0x1003, imm=0, pc_src=11 -> target 0x1002, misaligned:
  - pc=0x100, trap=1 for one cycle, epc=old pc, trap_cnt=1.
  - rs1=0x1001 -> target 0x1000 -> no trap, pc=0x1000.
- Trap return, and TRAP-state input masking:
  - During the TRAP cycle drive trap_ret=1, stall=1 -> ignored, pc stays 0x100.
  - Next cycle trap_ret=1 -> pc=epc.
  - trap_ret with stall=1 in RUN -> pc=epc.
- Wrap-around and saturation:
  - WIDTH=8, pc=0xFC, pc_src=00 -> pc=0x00, no trap.
  - CNT_W=2: force 5 traps -> trap_cnt sequence 1,2,3,3,3.
- Reset mid-trap: rst=0 on the TRAP cycle -> next cycle pc=RESET_VEC, trap=0, trap_cnt=0, state RUN.
